// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: read ports, writeback, issue and scoreboard status.
// master = decode/issue/writeback side, slave = the register file.
interface regfile_scoreboard_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR         = 2
);
    logic [NR*ADDR_WIDTH-1:0] raddr;
    logic [NR*DATA_WIDTH-1:0] rdata;
    logic [NR-1:0]            rbusy;
    logic                     wen;
    logic [ADDR_WIDTH-1:0]    waddr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     iss_valid;
    logic [ADDR_WIDTH-1:0]    iss_rd;
    logic                     flush;
    logic [ADDR_WIDTH:0]      busy_cnt;
    logic                     any_busy;

    modport master (
        output raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        input  rdata, rbusy, busy_cnt, any_busy
    );

    modport slave (
        input  raddr, wen, waddr, wdata, iss_valid, iss_rd, flush,
        output rdata, rbusy, busy_cnt, any_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// NR-read / 1-write integer register file (x0 = 0) with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy-clear to the read ports.
module regfile_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR         = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]    rf_reg [NREGS];
    logic [NREGS-1:0]         busy_reg;
    logic [NREGS-1:0]         busy_next;
    logic [ADDR_WIDTH:0]      busy_cnt_reg;
    logic [ADDR_WIDTH:0]      busy_cnt_next;
    logic [NR*DATA_WIDTH-1:0] rdata_all;
    logic [NR-1:0]            rbusy_all;

    // Issue is applied after the writeback clear so a newer producer keeps the register busy.
    always_comb begin
        busy_next = busy_reg;
        if (bus.flush) begin
            busy_next = '0;
        end else begin
            if (bus.wen)
                busy_next[bus.waddr] = 1'b0;
            if (bus.iss_valid)
                busy_next[bus.iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_next = '0;
        for (int i = 1; i < NREGS; i++)
            busy_cnt_next = busy_cnt_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                rf_reg[i] <= '0;
        end else if (bus.wen && (bus.waddr != '0)) begin
            rf_reg[bus.waddr] <= bus.wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] addr;
            logic                  hit;

            assign addr = bus.raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
            // Gated by rst_n so the ports read zero for the whole reset window.
            assign hit = rst_n && bus.wen && (bus.waddr == addr);
`else
            assign hit = 1'b0;
`endif
            assign rdata_all[gi*DATA_WIDTH +: DATA_WIDTH] =
                (addr == '0) ? '0 : (hit ? bus.wdata : rf_reg[addr]);
            assign rbusy_all[gi] = (addr != '0) && !hit && busy_reg[addr];
        end
    endgenerate

    assign bus.rdata    = rdata_all;
    assign bus.rbusy    = rbusy_all;
    assign bus.busy_cnt = busy_cnt_reg;
    assign bus.any_busy = (busy_cnt_reg != '0);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed scenarios followed by random traffic,
// expectations from an array-based reference model, checked by an independent monitor.
module tb_regfile_scoreboard;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int NREGS = 2 ** AW;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR)) bus ();

    regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [NR*DW-1:0] rdata;
        logic [NR-1:0]    rbusy;
        logic [AW:0]      cnt;
        logic             any;
        int               id;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] rf_m   [NREGS];
    bit            busy_m [NREGS];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_txn    = 0;

    function automatic void model_reset();
        for (int r = 0; r < NREGS; r++) begin
            rf_m[r]   = '0;
            busy_m[r] = 1'b0;
        end
    endfunction

    // Apply the inputs that were present at the clock edge that just occurred.
    function automatic void model_edge();
        if (!rst_n) return;
        if (bus.flush) begin
            for (int r = 0; r < NREGS; r++) busy_m[r] = 1'b0;
        end else begin
            if (bus.wen && bus.waddr != 0) busy_m[bus.waddr] = 1'b0;
            if (bus.iss_valid && bus.iss_rd != 0) busy_m[bus.iss_rd] = 1'b1;
        end
        if (bus.wen && bus.waddr != 0) rf_m[bus.waddr] = bus.wdata;
    endfunction

    function automatic void push_expect();
        exp_t          e;
        logic [AW-1:0] a;
        int            c;
        c = 0;
        for (int p = 0; p < NR; p++) begin
            a = bus.raddr[p*AW +: AW];
            if (a == 0) begin
                e.rdata[p*DW +: DW] = '0;
                e.rbusy[p]          = 1'b0;
            end else if (BYP && rst_n && bus.wen && bus.waddr == a) begin
                e.rdata[p*DW +: DW] = bus.wdata;
                e.rbusy[p]          = 1'b0;
            end else begin
                e.rdata[p*DW +: DW] = rf_m[a];
                e.rbusy[p]          = busy_m[a];
            end
        end
        for (int r = 0; r < NREGS; r++) c += int'(busy_m[r]);
        e.cnt = c[AW:0];
        e.any = (c != 0);
        e.id  = n_txn;
        n_txn++;
        exp_q.push_back(e);
    endfunction

    function automatic void chk(string nm, int id, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s txn %0d: got %h expected %h", nm, id, act, req);
        end
    endfunction

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NR; p++) begin
                    chk($sformatf("rdata%0d", p), e.id, 64'(bus.rdata[p*DW +: DW]), 64'(e.rdata[p*DW +: DW]));
                    chk($sformatf("rbusy%0d", p), e.id, 64'(bus.rbusy[p]), 64'(e.rbusy[p]));
                end
                chk("busy_cnt", e.id, 64'(bus.busy_cnt), 64'(e.cnt));
                chk("any_busy", e.id, 64'(bus.any_busy), 64'(e.any));
                $display("txn %0d raddr=%h rdata=%h rbusy=%b busy_cnt=%0d", e.id, bus.raddr, bus.rdata, bus.rbusy, bus.busy_cnt);
            end
        end
    end

    task automatic drive(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit iv, input logic [AW-1:0] rd, input bit fl,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        bus.wen       = w;
        bus.waddr     = wa;
        bus.wdata     = wd;
        bus.iss_valid = iv;
        bus.iss_rd    = rd;
        bus.flush     = fl;
        bus.raddr     = {ra1, ra0};
    endtask

    task automatic cyc(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit iv, input logic [AW-1:0] rd, input bit fl,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        @(posedge clk);
        #1;
        model_edge();
        drive(w, wa, wd, iv, rd, fl, ra0, ra1);
        push_expect();
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #1;
        model_edge();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd6, 5'd6);
        #2;
        rst_n = 1'b0;
        model_reset();
        push_expect();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin : stim
        logic [AW-1:0] wa, rd, ra0, ra1;
        model_reset();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        for (int a = 0; a < NREGS; a++)
            cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'(a), 5'(NREGS - 1 - a));

        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
        cyc(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
        cyc(1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 1'b0, 5'd0, 5'd5);
        cyc(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

        cyc(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
        cyc(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
        cyc(1'b1, 5'd7, 32'hCAFE0007, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        cyc(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd7, 5'd7);

        cyc(1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        cyc(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
        cyc(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd3, 5'd3);

        cyc(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd3, 5'd0);
        cyc(1'b0, 5'd0, 32'h0,        1'b1, 5'd1, 1'b0, 5'd1, 5'd3);
        cyc(1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 5'd1, 5'd2);
        cyc(1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 1'b0, 5'd2, 5'd4);
        cyc(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b1, 5'd4, 5'd9);
        cyc(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd9, 5'd1);

        cyc(1'b1, 5'd6, 32'h55,       1'b1, 5'd6, 1'b0, 5'd6, 5'd0);
        cyc(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd6, 5'd6);
        async_reset_check();
        cyc(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd6, 5'd5);

        for (int n = 0; n < 300; n++) begin
            wa  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            ra0 = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, NREGS - 1));
            cyc(1'($urandom_range(0, 1)), wa, $urandom,
                ($urandom_range(0, 9) < 4), rd, ($urandom_range(0, 15) == 0), ra0, ra1);
        end
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", n_txn, 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the NPC core: NR read ports, one write port, register 0 hardwired to zero.
- Adds an asynchronous active-low reset that clears all registers.
- Adds a per-register busy scoreboard: set on issue, cleared on writeback, bulk-cleared on flush. Decode uses it to detect RAW hazards.
- Adds optional write-to-read bypass.
- Sits between decode/issue and writeback; replaces the plain two-port register file.

Parameters:
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register width in bits.
- NR, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr  in  NR*ADDR_WIDTH  packed read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NR*DATA_WIDTH  packed read data, combinational.
- rbusy  out  NR  per-port busy flag for the addressed register, combinational.
- wen  in  1  writeback valid.
- waddr  in  ADDR_WIDTH  writeback destination.
- wdata  in  DATA_WIDTH  writeback data.
- iss_valid  in  1  an instruction with a destination issues this cycle.
- iss_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- flush  in  1  clear all busy bits; pipeline squash.
- busy_cnt  out  ADDR_WIDTH+1  number of busy registers, registered.
- any_busy  out  1  busy_cnt != 0.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - every rf entry = 0;
  - every busy bit = 0;
  - busy_cnt = 0, any_busy = 0;
  - rdata = 0 and rbusy = 0 for every port.
- Reset asserted mid-operation clears all state immediately, without waiting for clk. Writes/issues presented in the same cycle are lost.
- Write: on posedge, if wen && waddr != 0, rf[waddr] <= wdata. A write to address 0 is ignored.
- Read port i:
  - raddr_i == 0 -> rdata_i = 0, rbusy_i = 0.
  - Otherwise rdata_i = rf[raddr_i] and rbusy_i = busy[raddr_i], subject to the bypass feature.
- Busy update per register r != 0, evaluated at posedge in this priority order:
  1. flush=1 -> busy[r] <= 0 for all r. A simultaneous iss_valid is also dropped; flush wins.
  2. iss_valid && iss_rd == r -> busy[r] <= 1. Set wins over a same-cycle writeback clear of the same r, because the newer producer is outstanding.
  3. wen && waddr == r -> busy[r] <= 0.
  4. Otherwise busy[r] holds.
- busy[0] is constant 0. iss_valid with iss_rd == 0 has no effect.
- Issue to an already-busy register keeps it busy (WAW); the first writeback then clears it. Decode must stall on WAW; the block does not count per-register producers.
- busy_cnt is a registered population count of the busy vector, updated in the same edge as busy. Range 0..2**ADDR_WIDTH-1.
- Issue-side changes are never visible on rbusy in the same cycle. A register issued in cycle N reads busy from cycle N+1.
- Port outputs are independent; NR ports may address the same register with identical results.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: for port i with raddr_i != 0 and wen && waddr == raddr_i:
  - rdata_i = wdata, same-cycle forwarding;
  - rbusy_i = 0 unless busy will be re-set by a same-cycle issue to that register — no, rbusy_i = 0 regardless of iss_valid, since issue effects are not visible until N+1.
- Not defined:
  - rdata_i = rf[raddr_i] always; new data is visible the cycle after the write edge.
  - rbusy_i = busy[raddr_i] stored value; clears the cycle after writeback.

Test Plan:
- Reset release, then read every address on all ports -> rdata=0, rbusy=0, busy_cnt=0.
- Write x5=0xDEADBEEF (wen=1), next cycle read raddr0=5 -> 0xDEADBEEF. Write x0=0x1234, then read x0 -> 0.
- iss_valid, iss_rd=7 -> next cycle rbusy=1 on a port reading 7, busy_cnt=1. Writeback waddr=7 -> with REGFILE_BYPASS_EN, same-cycle rdata=wdata and rbusy=0; without it, rbusy=0 and new data the following cycle. busy_cnt returns to 0.
- Same-cycle iss_valid iss_rd=3 and wen waddr=3 with x3 busy -> x3 still busy next cycle, busy_cnt unchanged.
- Issue x1, x2, x4 over three cycles (busy_cnt=3), then flush with iss_valid iss_rd=9 -> busy_cnt=0, all rbusy=0, x9 not busy.
- Issue x6 and write x6=0x55, drop rst_n asynchronously between edges -> busy_cnt/any_busy go 0 immediately; x6 reads 0 after release.
